// File: rtl/uart_flow_ctrl_tx.sv
// uart_flow_ctrl_tx: XON/XOFF software flow control for the host link.
// Tracks how full the UART-to-parser FIFO is from its write/read strobes and
// tells the host to pause (XOFF) or resume (XON) over a dedicated TX line.
module uart_flow_ctrl_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned COUNTER_BITS = 13,
  parameter int unsigned LEVEL_BITS   = 10,
  parameter int unsigned HIGH_MARK    = 768,
  parameter int unsigned LOW_MARK     = 256,
  parameter logic [7:0]  XON_CHAR     = 8'h11,
  parameter logic [7:0]  XOFF_CHAR    = 8'h13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  wr_done,
  input  logic                  rd_done,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  xoff_active,
  output logic [LEVEL_BITS-1:0] level
);

  localparam logic [COUNTER_BITS-1:0] BAUD_LAST = COUNTER_BITS'(CLKS_PER_BIT - 1);
  localparam logic [LEVEL_BITS-1:0]   HIGH_LVL  = LEVEL_BITS'(HIGH_MARK);
  localparam logic [LEVEL_BITS-1:0]   LOW_LVL   = LEVEL_BITS'(LOW_MARK);
  localparam logic [LEVEL_BITS-1:0]   LEVEL_MAX = '1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // SENT_NONE only exists after reset so that an XON always goes out first.
  typedef enum logic [1:0] {
    SENT_NONE,
    SENT_XON,
    SENT_XOFF
  } sent_e;

  logic [LEVEL_BITS-1:0]   level_q;
  logic [LEVEL_BITS-1:0]   level_d;
  tx_state_e               state_q;
  sent_e                   sent_q;
  sent_e                   desired;
  logic                    need_frame;
  logic [7:0]              next_char;
  logic [7:0]              shift_q;
  logic [COUNTER_BITS-1:0] baud_q;
  logic [2:0]              bit_q;
  logic                    uart_tx_q;
  logic                    tx_busy_q;

  // Next occupancy: simultaneous write and read cancel, both ends saturate.
  always_comb begin
    level_d = level_q;
    if (wr_done && !rd_done && (level_q != LEVEL_MAX)) begin
      level_d = level_q + 1'b1;
    end else if (rd_done && !wr_done && (level_q != '0)) begin
      level_d = level_q - 1'b1;
    end
  end

  // Occupancy register, frozen whenever the clock enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (clk_en) begin
      level_q <= level_d;
    end
  end

  // Watermark decision with hysteresis: between the marks keep what was sent.
  always_comb begin
    desired = sent_q;
    if (level_q >= HIGH_LVL) begin
      desired = SENT_XOFF;
    end else if (level_q <= LOW_LVL) begin
      desired = SENT_XON;
    end
    need_frame = (desired != sent_q);
    next_char  = (desired == SENT_XOFF) ? XOFF_CHAR : XON_CHAR;
  end

  // Frame serializer; a pending change is picked up at the end of STOP so a
  // follow-up character starts without an idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      sent_q    <= SENT_NONE;
      shift_q   <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      uart_tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        TX_IDLE: begin
          uart_tx_q <= 1'b1;
          if (need_frame) begin
            state_q   <= TX_START;
            sent_q    <= desired;
            shift_q   <= next_char;
            baud_q    <= '0;
            bit_q     <= '0;
            uart_tx_q <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            state_q   <= TX_DATA;
            uart_tx_q <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q   <= TX_STOP;
              uart_tx_q <= 1'b1;
            end else begin
              bit_q     <= bit_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              uart_tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (need_frame) begin
              state_q   <= TX_START;
              sent_q    <= desired;
              shift_q   <= next_char;
              bit_q     <= '0;
              uart_tx_q <= 1'b0;
              tx_busy_q <= 1'b1;
            end else begin
              state_q   <= TX_IDLE;
              uart_tx_q <= 1'b1;
              tx_busy_q <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          uart_tx_q <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx     = uart_tx_q;
  assign tx_busy     = tx_busy_q;
  assign xoff_active = (sent_q == SENT_XOFF);
  assign level       = level_q;

endmodule

// File: tb/tb_uart_flow_ctrl_tx.sv
// tb_uart_flow_ctrl_tx: self-checking bench for the XON/XOFF transmitter.
// A behavioural model tracks occupancy, the last character committed and how
// many cycles of the current 10-bit frame remain; every step compares the DUT
// outputs against it, and scenario tasks add explicit spot checks.
module tb_uart_flow_ctrl_tx;

  localparam int CPB   = 4;
  localparam int LB    = 5;
  localparam int HIGH  = 24;
  localparam int LOW   = 8;
  localparam int LMAX  = 31;
  localparam int FRAME = 10 * CPB;
  localparam logic [7:0] XON  = 8'h11;
  localparam logic [7:0] XOFF = 8'h13;

  logic clk;
  logic reset;
  logic clkEn;
  logic wrDone;
  logic rdDone;
  logic uartTx;
  logic txBusy;
  logic xoffActive;
  logic [LB-1:0] level;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = nothing sent yet, 1 = XON, 2 = XOFF.
  int mLevel = 0;
  int mSent  = 0;
  int mRem   = 0;
  logic [7:0] mChar = 8'hFF;

  // Start bit, then 0x11 LSB first, then stop bit (index 0 = start bit).
  logic [9:0] xonPat = 10'b1000100010;

  uart_flow_ctrl_tx #(
    .CLKS_PER_BIT(CPB),
    .COUNTER_BITS(3),
    .LEVEL_BITS(LB),
    .HIGH_MARK(HIGH),
    .LOW_MARK(LOW),
    .XON_CHAR(XON),
    .XOFF_CHAR(XOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clkEn),
    .wr_done(wrDone),
    .rd_done(rdDone),
    .uart_tx(uartTx),
    .tx_busy(txBusy),
    .xoff_active(xoffActive),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a 40-cycle busy window; the transmitter is free
  // to commit a new character when idle or in the last cycle of a frame.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLevel = 0;
      mSent  = 0;
      mRem   = 0;
      mChar  = 8'hFF;
    end else if (clkEn) begin : modelStep
      int want;
      want = (mLevel >= HIGH) ? 2 : ((mLevel <= LOW) ? 1 : mSent);
      if ((mRem <= 1) && (want != mSent)) begin
        mSent = want;
        mChar = (want == 2) ? XOFF : XON;
        mRem  = FRAME;
      end else if (mRem > 0) begin
        mRem = mRem - 1;
      end
      if (wrDone && !rdDone && (mLevel < LMAX)) mLevel = mLevel + 1;
      else if (rdDone && !wrDone && (mLevel > 0)) mLevel = mLevel - 1;
    end
  end

  // Expected {uart_tx, tx_busy, xoff_active, level} derived from the model.
  function automatic logic [8:0] modelVec();
    logic tx;
    int pos;
    tx = 1'b1;
    if (mRem > 0) begin
      pos = (FRAME - mRem) / CPB;
      if (pos == 0) tx = 1'b0;
      else if (pos <= 8) tx = mChar[pos-1];
    end
    return {tx, (mRem > 0), (mSent == 2), LB'(mLevel)};
  endfunction

  // Drive one cycle of inputs and return at the next falling edge.
  task applyStimulus(input logic w, input logic r, input logic en);
    wrDone = w;
    rdDone = r;
    clkEn  = en;
    @(negedge clk);
  endtask

  // Reset values, then the mandatory XON frame after release.
  task test_reset();
    reset = 1'b1;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checks++;
    if (uartTx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", uartTx); end
    checks++;
    if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", txBusy); end
    checks++;
    if (xoffActive !== 1'b0) begin failures++; $display("[TB] FAIL reset_xoff: got %b expected 0", xoffActive); end
    checks++;
    if (level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    reset = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      applyStimulus(0, 0, 1);
      checks++;
      if ({uartTx, txBusy, xoffActive} !== {xonPat[c/CPB], 2'b10}) begin
        failures++;
        $display("[TB] FAIL boot_xon c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive}, {xonPat[c/CPB], 2'b10});
      end
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL boot_model c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL boot_end: got %b expected 100", {uartTx, txBusy, xoffActive});
    end
  endtask

  // Fill to the high mark; XOFF must start two cycles after the last write.
  task test_xoff();
    logic [7:0] rx;
    repeat (HIGH) begin
      applyStimulus(1, 0, 1);
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL xoff_fill: got %b expected %b", {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    checks++;
    if ({uartTx, level} !== {1'b1, 5'd24}) begin
      failures++;
      $display("[TB] FAIL xoff_level: got tx=%b level=%0d expected tx=1 level=24", uartTx, level);
    end
    applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL xoff_latency: got %b expected 011", {uartTx, txBusy, xoffActive});
    end
    rx = 8'h00;
    for (int c = 1; c < FRAME; c++) begin
      applyStimulus(0, 0, 1);
      if ((c % CPB == CPB/2) && (c/CPB >= 1) && (c/CPB <= 8)) rx[c/CPB-1] = uartTx;
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL xoff_frame c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    checks++;
    if (rx !== XOFF) begin failures++; $display("[TB] FAIL xoff_char: got %h expected %h", rx, XOFF); end
    applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy} !== 2'b10) begin failures++; $display("[TB] FAIL xoff_end: got %b expected 10", {uartTx, txBusy}); end
  endtask

  // Drain from 24 to 8: nothing on the line until the low mark, then XON.
  task test_xon();
    logic [7:0] rx;
    repeat (HIGH - LOW) begin
      applyStimulus(0, 1, 1);
      checks++;
      if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL xon_no_early: got busy=%b expected 0 level=%0d", txBusy, level); end
    end
    checks++;
    if ({level, xoffActive} !== {5'd8, 1'b1}) begin
      failures++;
      $display("[TB] FAIL xon_level: got level=%0d xoff=%b expected level=8 xoff=1", level, xoffActive);
    end
    applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL xon_start: got %b expected 010", {uartTx, txBusy, xoffActive});
    end
    rx = 8'h00;
    for (int c = 1; c <= FRAME; c++) begin
      applyStimulus(0, 0, 1);
      if ((c % CPB == CPB/2) && (c/CPB >= 1) && (c/CPB <= 8)) rx[c/CPB-1] = uartTx;
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL xon_frame c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    checks++;
    if (rx !== XON) begin failures++; $display("[TB] FAIL xon_char: got %h expected %h", rx, XON); end
  endtask

  // With the enable low, write pulses must not move the level.
  task test_clk_en();
    repeat (6) begin
      applyStimulus(1, 0, 0);
      checks++;
      if (level !== 5'd8) begin failures++; $display("[TB] FAIL clk_en_freeze: got %0d expected 8", level); end
    end
    applyStimulus(1, 0, 1);
    checks++;
    if (level !== 5'd9) begin failures++; $display("[TB] FAIL clk_en_resume: got %0d expected 9", level); end
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    checks++;
    if ({txBusy, level} !== {1'b0, 5'd8}) begin
      failures++;
      $display("[TB] FAIL clk_en_back: got busy=%b level=%0d expected busy=0 level=8", txBusy, level);
    end
  endtask

  // Watermark crossings while an XOFF frame is on the line.
  task test_mid_frame();
    repeat (HIGH - LOW) applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    for (int c = 1; c <= FRAME; c++) begin
      applyStimulus(0, (c <= HIGH - LOW), 1);
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL drain_model c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL drain_back_to_back: got %b expected 010", {uartTx, txBusy, xoffActive});
    end
    repeat (FRAME) applyStimulus(0, 0, 1);
    checks++;
    if (txBusy !== 1'b0) begin failures++; $display("[TB] FAIL drain_xon_end: got %b expected 0", txBusy); end
    repeat (HIGH - LOW) applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    for (int c = 1; c <= FRAME + 20; c++) begin
      applyStimulus((c > HIGH - LOW) && (c <= 28), (c <= HIGH - LOW), 1);
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL refill_model c=%0d: got %b expected %b", c, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
      if (c == FRAME) begin
        checks++;
        if ({uartTx, txBusy, xoffActive, level} !== {3'b101, 5'd20}) begin
          failures++;
          $display("[TB] FAIL refill_no_frame: got %b expected 10110100", {uartTx, txBusy, xoffActive, level});
        end
      end
    end
  endtask

  // Cancelling strobes and saturation at both ends of the counter.
  task test_saturation();
    repeat (10) applyStimulus(0, 1, 1);
    repeat (3) applyStimulus(1, 1, 1);
    checks++;
    if ({txBusy, level} !== {1'b0, 5'd10}) begin
      failures++;
      $display("[TB] FAIL both_strobes: got busy=%b level=%0d expected busy=0 level=10", txBusy, level);
    end
    repeat (40) applyStimulus(1, 0, 1);
    checks++;
    if (level !== 5'd31) begin failures++; $display("[TB] FAIL sat_high: got %0d expected 31", level); end
    for (int i = 0; i < LMAX + 3; i++) begin
      applyStimulus(0, 1, 1);
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL sat_drain i=%0d: got %b expected %b", i, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
    checks++;
    if (level !== 5'd0) begin failures++; $display("[TB] FAIL sat_low: got %0d expected 0", level); end
    repeat (FRAME + 5) applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL sat_settle: got %b expected 100", {uartTx, txBusy, xoffActive});
    end
  endtask

  // Reset during data bit 3 of an XOFF frame, then the XON frame is resent.
  task test_reset_mid_frame();
    repeat (HIGH) applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    repeat (17) applyStimulus(0, 0, 1);
    checks++;
    if ({uartTx, txBusy, xoffActive} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL rst_pre: got %b expected 011", {uartTx, txBusy, xoffActive});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({uartTx, txBusy, xoffActive, level} !== {3'b100, 5'd0}) begin
      failures++;
      $display("[TB] FAIL rst_async: got %b expected 10000000", {uartTx, txBusy, xoffActive, level});
    end
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    reset = 1'b0;
    for (int c = 0; c <= FRAME; c++) begin
      applyStimulus(0, 0, 1);
      checks++;
      if ({uartTx, txBusy} !== ((c < FRAME) ? {xonPat[c/CPB], 1'b1} : 2'b10)) begin
        failures++;
        $display("[TB] FAIL rst_resend c=%0d: got %b", c, {uartTx, txBusy});
      end
    end
  endtask

  // Random traffic in alternating fill/drain phases with a sporadic enable.
  task test_random();
    for (int i = 0; i < 3000; i++) begin
      int bias;
      logic w;
      logic r;
      logic en;
      bias = ((i / 250) % 2 == 0) ? 70 : 25;
      w  = ($urandom_range(99) < bias);
      r  = ($urandom_range(99) < (95 - bias));
      en = ($urandom_range(9) != 0);
      applyStimulus(w, r, en);
      checks++;
      if ({uartTx, txBusy, xoffActive, level} !== modelVec()) begin
        failures++;
        $display("[TB] FAIL random i=%0d: got %b expected %b", i, {uartTx, txBusy, xoffActive, level}, modelVec());
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    clkEn  = 1'b1;
    wrDone = 1'b0;
    rdDone = 1'b0;
    @(negedge clk);
    test_reset();
    test_xoff();
    test_xon();
    test_clk_en();
    test_mid_frame();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
